mem_port_ctrl: RTL

//  Memory port stage between the multicycle control FSM and the single-port BSRAM.
//  - Turns FSM strobes (ce/oce/wre/IorD/irWrite) into BSRAM cycles.
//  - Tracks read latency and steers returned data into the IR or the MDR.
//  - Exports inst_opcode back to the control FSM.

---
 rtl/mem_port_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_ctrl.sv
// ---------------------------------------------------------------------------
// mem_port_ctrl
// Memory port stage between the multicycle control FSM and a single-port
// BSRAM. It turns FSM strobes into BSRAM cycles and tracks reads in flight.
// Returned data is steered into the instruction register (IR) or the memory
// data register (MDR). The IR opcode field is exported back to the FSM.
//
// Parameters
//   ADDR_W    BSRAM word-address width
//   DATA_W    data width (IR is always 32 bits)
//   READ_LAT  BSRAM read latency: 1 = bypass, 2 = pipeline (uses oce)
//   IR_RST    IR reset value (NOP)
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   ce_i/oce_i/wre_i  FSM access request, output-reg enable, write enable
//   iord_sel          address select: 0 = pc (fetch), 1 = alu_out (data)
//   ir_write_en       tags a read as an instruction fetch
//   pc, alu_out       byte addresses for fetch / data access
//   store_data        write data
//   mem_dout          BSRAM read data
//   mem_ce/oce/wre    BSRAM strobes (combinational, forced low in reset)
//   mem_ad, mem_din   BSRAM word address and write data (combinational)
//   ir_q, inst_opcode instruction register and its opcode field
//   mdr_q             memory data register
//   rd_valid          one-cycle pulse after the IR or MDR is updated
//   busy              a read is in flight
//   misalign_err      sticky misaligned-access flag (MEM_MISALIGN_CHECK_EN only)
//
// Build option
//   MEM_MISALIGN_CHECK_EN  When defined, accesses with addr[1:0] != 0 are
//                          suppressed and flagged on misalign_err. When it is
//                          not defined, addr[1:0] is ignored.
// ---------------------------------------------------------------------------
module mem_port_ctrl #(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned READ_LAT = 1,
   parameter logic [31:0] IR_RST   = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce_i,
   input  logic              oce_i,
   input  logic              wre_i,
   input  logic              iord_sel,
   input  logic              ir_write_en,
   input  logic [31:0]       pc,
   input  logic [31:0]       alu_out,
   input  logic [DATA_W-1:0] store_data,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              mem_ce,
   output logic              mem_oce,
   output logic              mem_wre,
   output logic [ADDR_W-1:0] mem_ad,
   output logic [DATA_W-1:0] mem_din,
   output logic [31:0]       ir_q,
   output logic [6:0]        inst_opcode,
   output logic [DATA_W-1:0] mdr_q,
   output logic              rd_valid,
   output logic              busy
`ifdef MEM_MISALIGN_CHECK_EN
   ,
   output logic              misalign_err
`endif
);

   localparam bit PIPE_MODE = (READ_LAT == 2);

   logic [31:0]         addr_c;
   logic                misaligned_c;
   logic                acc_c;
   logic                push_c;
   logic                head_vld_c;
   logic                head_dst_c;
   logic [READ_LAT-1:0] pv_q, pv_d;
   logic [READ_LAT-1:0] pd_q, pd_d;
   logic [31:0]         ir_d;
   logic [DATA_W-1:0]   mdr_d;
   logic                rd_valid_q, rd_valid_d;
   logic                busy_q, busy_d;
   logic                unused_addr_bits;

   // Address mux; only the word-address bits reach the BSRAM
   assign addr_c = iord_sel ? alu_out : pc;

`ifdef MEM_MISALIGN_CHECK_EN
   assign misaligned_c = (addr_c[1:0] != 2'b00);
`else
   assign misaligned_c = 1'b0;
`endif

   // A misaligned access is dropped entirely: no strobe, no write, no push
   assign acc_c  = ce_i & ~misaligned_c;
   assign push_c = acc_c & ~wre_i;

   assign unused_addr_bits = ^{addr_c[31:ADDR_W+2], addr_c[1:0]};

   // BSRAM strobes, held off while reset is asserted
   assign mem_ce  = acc_c & ~rst;
   assign mem_wre = acc_c & wre_i & ~rst;
   assign mem_oce = PIPE_MODE & oce_i & ~rst;
   assign mem_ad  = addr_c[ADDR_W+1:2];
   assign mem_din = store_data;

   // Read-tracking shift pipe: stage 0 takes the new read, last stage is head
   generate
      if (READ_LAT > 1) begin : g_pipe_deep
         assign pv_d = {pv_q[READ_LAT-2:0], push_c};
         assign pd_d = {pd_q[READ_LAT-2:0], push_c & ir_write_en};
      end else begin : g_pipe_one
         assign pv_d = push_c;
         assign pd_d = push_c & ir_write_en;
      end
   endgenerate

   assign head_vld_c = pv_q[READ_LAT-1];
   assign head_dst_c = pd_q[READ_LAT-1];

   // Completion: head entry steers BSRAM data into IR or MDR
   always_comb begin
      ir_d       = ir_q;
      mdr_d      = mdr_q;
      rd_valid_d = head_vld_c;
      busy_d     = |pv_d;
      if (head_vld_c) begin
         if (head_dst_c) begin
            ir_d = 32'(mem_dout);
         end else begin
            mdr_d = mem_dout;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pv_q       <= '0;
         pd_q       <= '0;
         ir_q       <= IR_RST;
         mdr_q      <= '0;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         pv_q       <= pv_d;
         pd_q       <= pd_d;
         ir_q       <= ir_d;
         mdr_q      <= mdr_d;
         rd_valid_q <= rd_valid_d;
         busy_q     <= busy_d;
      end
   end

`ifdef MEM_MISALIGN_CHECK_EN
   logic misalign_q, misalign_d;

   // Sticky until reset
   assign misalign_d = misalign_q | (ce_i & misaligned_c);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end

   assign misalign_err = misalign_q;
`endif

   assign rd_valid    = rd_valid_q;
   assign busy        = busy_q;
   assign inst_opcode = ir_q[6:0];

endmodule
